pe_result_collector: RTL and testbench

Sink-side partner of the pipelined PE. It consumes the PE's unstoppable valid/result stream of Q16.16 partial sums and accumulates a configurable number of beats per output group. Each completed group is rounded and saturated to Q8.8, then buffered in a small FIFO. The FIFO drains to the next stage over a valid/ready handshake. It sits at the output edge of a PE column or array, between the last PE stage and the writeback/activation logic.

---
 rtl/pe_result_collector.sv | 129 ++++++++++++
 tb/tb_pe_result_collector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Accumulates the PE's Q16.16 result stream into groups of cfg_len beats, rounds and
// saturates each group to Q8.8, and buffers the results in a small FIFO for a valid/ready consumer.
module pe_result_collector #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [CNT_WIDTH-1:0]  cfg_len,
   input  logic                  in_valid,
   input  logic [ACC_WIDTH-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output logic                  busy,
   output logic                  overflow
);
   localparam int unsigned SUM_W = ACC_WIDTH + CNT_WIDTH;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(64'd1 << (FRAC_BITS - 1));
   localparam logic signed [SUM_W-1:0] MAX_Q = SUM_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
   localparam logic signed [SUM_W-1:0] MIN_Q = ~MAX_Q;

   logic signed [SUM_W-1:0] acc;
   logic [CNT_WIDTH-1:0]    count;
   logic [CNT_WIDTH-1:0]    len_q;

   logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
   logic                    mem_sat  [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W:0]          fcnt;

   logic                    first;
   logic                    last;
   logic [CNT_WIDTH-1:0]    cur_len;
   logic [CNT_WIDTH:0]      count_inc;
   logic signed [SUM_W-1:0] in_ext;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] rnd;
   logic [DATA_WIDTH-1:0]   res_data;
   logic                    res_sat;
   logic                    full;
   logic                    push;
   logic                    pop;
   logic                    do_push;

   assign out_valid = (fcnt != '0);
   assign out_data  = mem_data[rd_ptr];
   assign out_sat   = mem_sat[rd_ptr];
   assign busy      = (count != '0);
   assign full      = (fcnt == (PTR_W + 1)'(FIFO_DEPTH));

   // Group bookkeeping, sum, and Q16.16 -> Q8.8 round-half-up with saturation
   always_comb begin
      first     = (count == '0);
      cur_len   = len_q;
      if (first) cur_len = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
      count_inc = {1'b0, count} + (CNT_WIDTH + 1)'(1);
      last      = (count_inc == {1'b0, cur_len});
      in_ext    = {{CNT_WIDTH{in_data[ACC_WIDTH-1]}}, in_data};
      sum       = (first ? '0 : acc) + in_ext;
      rnd       = (sum + HALF) >>> FRAC_BITS;
      res_sat   = 1'b0;
      res_data  = rnd[DATA_WIDTH-1:0];
      if (rnd > MAX_Q) begin
         res_data = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
         res_sat  = 1'b1;
      end else if (rnd < MIN_Q) begin
         res_data = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
         res_sat  = 1'b1;
      end
      push    = in_valid && last;
      pop     = out_valid && out_ready;
      do_push = push && (!full || pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         count    <= '0;
         len_q    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fcnt     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_data[i] <= '0;
            mem_sat[i]  <= 1'b0;
         end
      end else if (clr) begin
         acc      <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fcnt     <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_valid) begin
            if (first) len_q <= cur_len;
            if (last) begin
               acc   <= '0;
               count <= '0;
            end else begin
               acc   <= sum;
               count <= count_inc[CNT_WIDTH-1:0];
            end
         end
         if (do_push) begin
            mem_data[wr_ptr] <= res_data;
            mem_sat[wr_ptr]  <= res_sat;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         // A completed group that finds the FIFO full (and no pop) is lost
         if (push && !do_push) overflow <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, pop})
            2'b10:   fcnt <= fcnt + (PTR_W + 1)'(1);
            2'b01:   fcnt <= fcnt - (PTR_W + 1)'(1);
            default: fcnt <= fcnt;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_result_collector.sv
// Directed self-checking bench for pe_result_collector.
module tb_pe_result_collector;
   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [7:0]  cfg_len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   pe_result_collector dut (
      .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; cfg_len = 8'd1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      checks++; if ({out_valid, out_data, out_sat, busy, overflow} !== 20'h0) begin
         errors++; $display("FAIL reset_outputs: got %b/%h/%b/%b/%b exp 0/0000/0/0/0", out_valid, out_data, out_sat, busy, overflow); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      cfg_len = 8'd1;
      beat(32'h0001_0000);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100 || out_sat !== 1'b0) begin
         errors++; $display("FAIL single_out: got v=%b d=%h s=%b exp v=1 d=0100 s=0", out_valid, out_data, out_sat); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single_pop: got v=%b exp 0", out_valid); end
   endtask

   task automatic test_group(input bit gap);
      int busy_cycles = 0;
      cfg_len = 8'd4;
      for (int i = 0; i < 4; i++) begin
         beat(32'h0000_8000);
         if (busy) busy_cycles++;
         if (gap && i < 3) begin
            step();
            if (busy) busy_cycles++;
         end
      end
      checks++; if (busy_cycles !== (gap ? 6 : 3)) begin
         errors++; $display("FAIL group_busy gap=%0d: got %0d exp %0d", gap, busy_cycles, gap ? 6 : 3); end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0200 || out_sat !== 1'b0) begin
         errors++; $display("FAIL group_out gap=%0d: got v=%b d=%h s=%b exp v=1 d=0200 s=0", gap, out_valid, out_data, out_sat); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL group_pop gap=%0d: got v=%b exp 0", gap, out_valid); end
   endtask

   task automatic test_round_sat();
      logic [7:0]  lens [6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
      logic [31:0] vin  [6] = '{32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_FF7F,
                                32'h7FFF_0000, 32'h8000_0000, 32'hFF80_0000};
      logic [15:0] vexp [6] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
      logic        sexp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         cfg_len = lens[i];
         for (int b = 0; b < int'(lens[i]); b++) beat(vin[i]);
         checks++; if (out_valid !== 1'b1 || out_data !== vexp[i] || out_sat !== sexp[i]) begin
            errors++; $display("FAIL round_sat[%0d] in=%h: got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                               i, vin[i], out_valid, out_data, out_sat, vexp[i], sexp[i]); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_d;
      cfg_len = 8'd1;
      for (int i = 1; i <= 5; i++) beat(32'(i) << 16);
      checks++; if (overflow !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_overflow: got ovf=%b v=%b exp 1/1", overflow, out_valid); end
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         exp_d = 16'(k) << 8;
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
            errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d); end
         step();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_empty: got v=%b exp 0", out_valid); end
      clr = 1'b1; step(); clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin
         errors++; $display("FAIL bp_clr_ovf: got %b exp 0", overflow); end
      for (int i = 1; i <= 4; i++) beat(32'(i) << 16);
      // full FIFO: push 6.0 while popping the head
      out_ready = 1'b1;
      beat(32'h0006_0000);
      checks++; if (overflow !== 1'b0) begin
         errors++; $display("FAIL full_pushpop_ovf: got %b exp 0", overflow); end
      for (int k = 0; k < 4; k++) begin
         exp_d = (k == 3) ? 16'h0600 : 16'(k + 2) << 8;
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
            errors++; $display("FAIL full_pushpop_drain[%0d]: got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d); end
         step();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin
         errors++; $display("FAIL full_pushpop_empty: got v=%b exp 0", out_valid); end
   endtask

   task automatic test_reset_clr();
      cfg_len = 8'd3;
      beat(32'h0001_0000);
      beat(32'h0001_0000);
      checks++; if (busy !== 1'b1) begin
         errors++; $display("FAIL midgroup_busy: got %b exp 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if ({out_valid, out_data, out_sat, busy, overflow} !== 20'h0) begin
         errors++; $display("FAIL midgroup_reset: got %b/%h/%b/%b/%b exp 0/0000/0/0/0", out_valid, out_data, out_sat, busy, overflow); end
      step();
      rst = 1'b0;
      step();
      for (int b = 0; b < 3; b++) beat(32'h0001_0000);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0300 || out_sat !== 1'b0) begin
         errors++; $display("FAIL fresh_group: got v=%b d=%h s=%b exp v=1 d=0300 s=0", out_valid, out_data, out_sat); end
      cfg_len = 8'd1;
      for (int i = 0; i < 4; i++) beat(32'h0001_0000);
      cfg_len = 8'd3;
      beat(32'h0001_0000);
      checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL preclr_state: got ovf=%b busy=%b exp 1/1", overflow, busy); end
      clr = 1'b1; in_valid = 1'b1; in_data = 32'h0001_0000;
      step();
      clr = 1'b0; in_valid = 1'b0;
      checks++; if (overflow !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL clr_state: got ovf=%b v=%b busy=%b exp 0/0/0", overflow, out_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_group(1'b0);
      test_group(1'b1);
      test_round_sat();
      test_backpressure();
      test_reset_clr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
